// File: rtl/qam16_ber_checker.sv
// qam16_ber_checker: hard-slices 16-QAM symbols back to Gray bits, syncs a
// PRBS-23 (x^23+x^18+1) reference to the received bit stream, and counts
// compared bits and bit errors while locked. A window whose error count is
// above LOL_THRESH drops lock.
// Optional feature macro: BERCHK_SNAPSHOT_EN adds snap_err/snap_vld, which
// report each window's error count at window end.
module qam16_ber_checker #(
  parameter logic signed [11:0] SLICE_THR  = 12'sd1024,
  parameter int unsigned        LOCK_LEN   = 64,
  parameter int unsigned        WIN_SYMS   = 1024,
  parameter int unsigned        LOL_THRESH = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic signed [11:0] sym_I,
  input  logic signed [11:0] sym_Q,
  input  logic               sym_valid,
  output logic [3:0]         rx_bits,
  output logic               rx_bits_vld,
  output logic               locked,
  output logic               lock_lost,
  output logic               win_done,
  output logic [47:0]        bit_count,
  output logic [31:0]        err_count
`ifdef BERCHK_SNAPSHOT_EN
  ,
  output logic [31:0]        snap_err,
  output logic               snap_vld
`endif
);

  localparam int WIN_W = (WIN_SYMS > 2) ? $clog2(WIN_SYMS) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_SYMS - 1);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t             state, state_d;
  logic [22:0]        lfsr, lfsr_d, lfsr_work;
  logic [4:0]         fill, fill_d;
  logic [15:0]        run, run_d;
  logic [WIN_W-1:0]   win_cnt, win_cnt_d;
  logic [31:0]        win_err, win_err_d, win_err_sum;
  logic [47:0]        bit_count_d;
  logic [31:0]        err_count_d;
  logic [48:0]        bit_sum;
  logic [32:0]        err_sum;
  logic [3:0]         sym_err;
  logic [2:0]         n_err;
  logic               win_done_d, lock_lost_d;

  // One axis of the Gray slicer; exact threshold hits go to the higher level.
  function automatic logic [1:0] slice_axis(input logic signed [11:0] x);
    if (x < -SLICE_THR)     return 2'b00;
    else if (x < 12'sd0)    return 2'b01;
    else if (x < SLICE_THR) return 2'b11;
    else                    return 2'b10;
  endfunction

  // Stage 1: register the sliced bits and their strobe.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      rx_bits     <= '0;
      rx_bits_vld <= 1'b0;
    end else begin
      rx_bits_vld <= sym_valid;
      if (sym_valid) rx_bits <= {slice_axis(sym_I), slice_axis(sym_Q)};
    end
  end

  // Run the four bits of a symbol through the reference, oldest bit first.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned, which would infer a latch.
    lfsr_work = lfsr;
    sym_err   = '0;
    for (int k = 3; k >= 0; k--) begin
      logic pred;
      pred       = lfsr_work[22] ^ lfsr_work[17];
      sym_err[k] = rx_bits[k] ^ pred;
      // Once locked the reference free-runs so received errors never corrupt it.
      lfsr_work  = {lfsr_work[21:0], (state == LOCKED) ? pred : rx_bits[k]};
    end
    n_err       = 3'($countones(sym_err));
    win_err_sum = win_err + 32'(n_err);
    bit_sum     = {1'b0, bit_count} + 49'd4;
    err_sum     = {1'b0, err_count} + 33'(n_err);
  end

  // Next-state, counter and pulse logic for the stage-2 checker.
  always_comb begin
    state_d     = state;
    lfsr_d      = lfsr;
    fill_d      = fill;
    run_d       = run;
    win_cnt_d   = win_cnt;
    win_err_d   = win_err;
    bit_count_d = bit_count;
    err_count_d = err_count;
    win_done_d  = 1'b0;
    lock_lost_d = 1'b0;

    if (rx_bits_vld) begin
      lfsr_d = lfsr_work;
      unique case (state)
        SEARCH: begin
          fill_d = fill + 5'd4;
          if ((fill + 5'd4) >= 5'd23) begin
            state_d = VERIFY;
            run_d   = '0;
          end
        end
        VERIFY: begin
          if (|sym_err) begin
            state_d = SEARCH;
            fill_d  = '0;
          end else begin
            run_d = run + 16'd4;
            if ((run + 16'd4) >= 16'(LOCK_LEN)) begin
              state_d   = LOCKED;
              win_cnt_d = '0;
              win_err_d = '0;
            end
          end
        end
        LOCKED: begin
          // A coincident clear discards this symbol from all counts.
          if (!clear) begin
            bit_count_d = bit_sum[48] ? '1 : bit_sum[47:0];
            err_count_d = err_sum[32] ? '1 : err_sum[31:0];
            if (win_cnt == WIN_LAST) begin
              win_done_d = 1'b1;
              win_cnt_d  = '0;
              win_err_d  = '0;
              if (win_err_sum > 32'(LOL_THRESH)) begin
                lock_lost_d = 1'b1;
                state_d     = SEARCH;
                fill_d      = '0;
              end
            end else begin
              win_cnt_d = win_cnt + 1'b1;
              win_err_d = win_err_sum;
            end
          end
        end
        default: begin
          state_d = SEARCH;
          fill_d  = '0;
        end
      endcase
    end

    if (clear) begin
      bit_count_d = '0;
      err_count_d = '0;
      win_cnt_d   = '0;
      win_err_d   = '0;
    end
  end

  // Stage 2 registers; locked trails the state so it falls after lock_lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEARCH;
      lfsr      <= '0;
      fill      <= '0;
      run       <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      bit_count <= '0;
      err_count <= '0;
      win_done  <= 1'b0;
      lock_lost <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_d;
      lfsr      <= lfsr_d;
      fill      <= fill_d;
      run       <= run_d;
      win_cnt   <= win_cnt_d;
      win_err   <= win_err_d;
      bit_count <= bit_count_d;
      err_count <= err_count_d;
      win_done  <= win_done_d;
      lock_lost <= lock_lost_d;
      locked    <= (state == LOCKED);
    end
  end

`ifdef BERCHK_SNAPSHOT_EN
  // Capture the closing window's error total at each window end.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_err <= '0;
      snap_vld <= 1'b0;
    end else begin
      snap_vld <= win_done_d;
      if (win_done_d) snap_err <= win_err_sum;
    end
  end
`endif

endmodule

// File: tb/tb_qam16_ber_checker.sv
// Self-checking bench for qam16_ber_checker: a cycle model predicts every
// output; expectations are queued when stimulus is driven and compared when
// the DUT produces them. Scenario tasks add their own targeted checks.
module tb_qam16_ber_checker;

  localparam int LOCK_LEN   = 64;
  localparam int WIN_SYMS   = 1024;
  localparam int LOL_THRESH = 256;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               clear = 1'b0;
  logic signed [11:0] sym_I = '0;
  logic signed [11:0] sym_Q = '0;
  logic               sym_valid = 1'b0;
  logic [3:0]         rx_bits;
  logic               rx_bits_vld;
  logic               locked;
  logic               lock_lost;
  logic               win_done;
  logic [47:0]        bit_count;
  logic [31:0]        err_count;
`ifdef BERCHK_SNAPSHOT_EN
  logic [31:0]        snap_err;
  logic               snap_vld;
`endif

  always #5 clk = ~clk;

  qam16_ber_checker #(
    .SLICE_THR (12'sd1024),
    .LOCK_LEN  (LOCK_LEN),
    .WIN_SYMS  (WIN_SYMS),
    .LOL_THRESH(LOL_THRESH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .sym_I      (sym_I),
    .sym_Q      (sym_Q),
    .sym_valid  (sym_valid),
    .rx_bits    (rx_bits),
    .rx_bits_vld(rx_bits_vld),
    .locked     (locked),
    .lock_lost  (lock_lost),
    .win_done   (win_done),
    .bit_count  (bit_count),
    .err_count  (err_count)
`ifdef BERCHK_SNAPSHOT_EN
    ,
    .snap_err   (snap_err),
    .snap_vld   (snap_vld)
`endif
  );

  typedef enum int {M_SEARCH, M_VERIFY, M_LOCKED} mstate_t;

  typedef struct {
    logic       vld;
    logic [3:0] bits;
  } rx_exp_t;

  typedef struct {
    logic        locked;
    logic        lock_lost;
    logic        win_done;
    logic [47:0] bits;
    logic [31:0] errs;
  } s2_exp_t;

  rx_exp_t rx_q[$];
  s2_exp_t s2_q[$];

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state.
  mstate_t     m_state;
  logic [22:0] m_lfsr;
  int          m_fill, m_run, m_win, m_werr;
  logic [47:0] m_bits;
  logic [31:0] m_errs;
  logic        p_v;
  logic [3:0]  p_bits;

  // Transmit-side PRBS-23 generator.
  logic [22:0] g;

  function automatic logic [1:0] exp_axis(input int x);
    if (x < -1024)     return 2'b00;
    else if (x < 0)    return 2'b01;
    else if (x < 1024) return 2'b11;
    else               return 2'b10;
  endfunction

  function automatic int level(input logic [1:0] p);
    case (p)
      2'b00:   return -1536;
      2'b01:   return -512;
      2'b11:   return 512;
      default: return 1536;
    endcase
  endfunction

  task automatic model_reset();
    m_state = M_SEARCH;
    m_lfsr  = '0;
    m_fill  = 0;
    m_run   = 0;
    m_win   = 0;
    m_werr  = 0;
    m_bits  = '0;
    m_errs  = '0;
    p_v     = 1'b0;
    p_bits  = '0;
  endtask

  // Outputs after one clock edge, given the symbol pending in stage 1.
  task automatic model_stage2(input logic clr, output s2_exp_t e);
    logic b, pr, mis;
    int   nerr;
    e.locked    = (m_state == M_LOCKED);
    e.win_done  = 1'b0;
    e.lock_lost = 1'b0;
    if (p_v) begin
      mis  = 1'b0;
      nerr = 0;
      for (int k = 3; k >= 0; k--) begin
        b  = p_bits[k];
        pr = m_lfsr[22] ^ m_lfsr[17];
        if (b !== pr) begin
          mis  = 1'b1;
          nerr = nerr + 1;
        end
        m_lfsr = {m_lfsr[21:0], (m_state == M_LOCKED) ? pr : b};
      end
      case (m_state)
        M_SEARCH: begin
          m_fill = m_fill + 4;
          if (m_fill >= 23) begin
            m_state = M_VERIFY;
            m_run   = 0;
          end
        end
        M_VERIFY: begin
          if (mis) begin
            m_state = M_SEARCH;
            m_fill  = 0;
          end else begin
            m_run = m_run + 4;
            if (m_run >= LOCK_LEN) begin
              m_state = M_LOCKED;
              m_win   = 0;
              m_werr  = 0;
            end
          end
        end
        default: begin
          if (!clr) begin
            m_bits = (m_bits > 48'hFFFF_FFFF_FFFB) ? '1 : m_bits + 48'd4;
            m_errs = (longint'(m_errs) + nerr > 64'h0_FFFF_FFFF) ? '1 : m_errs + 32'(nerr);
            m_werr = m_werr + nerr;
            m_win  = m_win + 1;
            if (m_win == WIN_SYMS) begin
              e.win_done = 1'b1;
              if (m_werr > LOL_THRESH) begin
                e.lock_lost = 1'b1;
                m_state     = M_SEARCH;
                m_fill      = 0;
              end
              m_win  = 0;
              m_werr = 0;
            end
          end
        end
      endcase
    end
    if (clr) begin
      m_bits = '0;
      m_errs = '0;
      m_win  = 0;
      m_werr = 0;
    end
    e.bits = m_bits;
    e.errs = m_errs;
  endtask

  // One clock: predict, queue, drive, then pop and compare at the negedge.
  task automatic step(input logic v, input int i, input int q, input logic clr, input logic r);
    rx_exp_t rx_e, rx_o;
    s2_exp_t s2_e, s2_o;
    if (r) begin
      model_reset();
      s2_e.locked = 1'b0; s2_e.lock_lost = 1'b0; s2_e.win_done = 1'b0;
      s2_e.bits   = '0;   s2_e.errs      = '0;
      rx_e.vld    = 1'b0; rx_e.bits      = '0;
    end else begin
      model_stage2(clr, s2_e);
      rx_e.vld  = v;
      rx_e.bits = {exp_axis(i), exp_axis(q)};
      p_v       = v;
      p_bits    = rx_e.bits;
    end
    rx_q.push_back(rx_e);
    s2_q.push_back(s2_e);

    sym_valid = v;
    sym_I     = 12'(i);
    sym_Q     = 12'(q);
    clear     = clr;
    rst       = r;
    @(posedge clk);
    @(negedge clk);
    sym_valid = 1'b0;
    clear     = 1'b0;
    rst       = 1'b0;

    rx_o = rx_q.pop_front();
    s2_o = s2_q.pop_front();
    n_vec++;
    if (rx_bits_vld !== rx_o.vld) begin
      n_miss++;
      $display("FAIL sb_rx_vld: got %0b want %0b at %0t", rx_bits_vld, rx_o.vld, $time);
    end
    if (rx_o.vld) begin
      n_vec++;
      if (rx_bits !== rx_o.bits) begin
        n_miss++;
        $display("FAIL sb_rx_bits: got %b want %b at %0t", rx_bits, rx_o.bits, $time);
      end
    end
    n_vec++;
    if ({locked, lock_lost, win_done} !== {s2_o.locked, s2_o.lock_lost, s2_o.win_done}) begin
      n_miss++;
      $display("FAIL sb_flags: got lk/ll/wd %b%b%b want %b%b%b at %0t", locked, lock_lost,
               win_done, s2_o.locked, s2_o.lock_lost, s2_o.win_done, $time);
    end
    n_vec++;
    if (bit_count !== s2_o.bits || err_count !== s2_o.errs) begin
      n_miss++;
      $display("FAIL sb_counts: got bits %0d errs %0d want bits %0d errs %0d at %0t",
               bit_count, err_count, s2_o.bits, s2_o.errs, $time);
    end
  endtask

  // mode 0: clean PRBS symbol, 1: all four bits inverted, 2: I and Q signs mirrored.
  task automatic send_sym(input int mode, input logic clr);
    logic [3:0] bits;
    logic       nb;
    int         i, q;
    for (int k = 3; k >= 0; k--) begin
      nb      = g[22] ^ g[17];
      g       = {g[21:0], nb};
      bits[k] = nb;
    end
    if (mode == 1) bits = ~bits;
    i = level(bits[3:2]);
    q = level(bits[1:0]);
    if (mode == 2) begin
      i = -i;
      q = -q;
    end
    step(1'b1, i, q, clr, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b0, 0, 0, 1'b0, 1'b1);
    step(1'b1, 1536, 1536, 1'b0, 1'b1);
    n_vec++;
    if ({rx_bits, rx_bits_vld, locked, lock_lost, win_done} !== 8'b0 ||
        bit_count !== 48'd0 || err_count !== 32'd0) begin
      n_miss++;
      $display("FAIL reset_state: got rx %b v %b lk %b ll %b wd %b bits %0d errs %0d want all 0",
               rx_bits, rx_bits_vld, locked, lock_lost, win_done, bit_count, err_count);
    end
  endtask

  task automatic test_lock();
    int lock_at = -1;
    g = 23'h3A5C71;
    for (int s = 1; s <= 200; s++) begin
      send_sym(0, 1'b0);
      if (locked === 1'b1 && lock_at < 0) lock_at = s;
    end
    idle();
    // Symbol 22 completes VERIFY; locked appears two clocks later.
    n_vec++;
    if (lock_at != 24) begin
      n_miss++;
      $display("FAIL lock_latency: got step %0d want 24", lock_at);
    end
    n_vec++;
    if (err_count !== 32'd0 || bit_count !== 48'd712) begin
      n_miss++;
      $display("FAIL lock_counts: got bits %0d errs %0d want 712 0", bit_count, err_count);
    end
  endtask

  task automatic test_single_err();
    logic [31:0] base = m_errs;
    send_sym(2, 1'b0);
    idle();
    n_vec++;
    if (err_count !== base + 32'd2 || locked !== 1'b1) begin
      n_miss++;
      $display("FAIL single_err: got errs %0d lk %b want %0d 1", err_count, locked, base + 32'd2);
    end
  endtask

  task automatic test_window_loss();
    logic [31:0] base;
    int          need, lock_at;
    need = (m_win == 0) ? 0 : WIN_SYMS - m_win;
    for (int s = 0; s < need; s++) send_sym(0, 1'b0);
    idle();
    base = m_errs;
    for (int s = 0; s < WIN_SYMS; s++) send_sym(1, 1'b0);
    idle();
    n_vec++;
    if (win_done !== 1'b1 || lock_lost !== 1'b1 || locked !== 1'b1 ||
        err_count !== base + 32'(4 * WIN_SYMS)) begin
      n_miss++;
      $display("FAIL window_loss: got wd %b ll %b lk %b errs %0d want 1 1 1 %0d",
               win_done, lock_lost, locked, err_count, base + 32'(4 * WIN_SYMS));
    end
    idle();
    n_vec++;
    if (locked !== 1'b0 || lock_lost !== 1'b0 || win_done !== 1'b0) begin
      n_miss++;
      $display("FAIL lock_drop: got lk %b ll %b wd %b want 0 0 0", locked, lock_lost, win_done);
    end
    lock_at = -1;
    for (int s = 1; s <= 30; s++) begin
      send_sym(0, 1'b0);
      if (locked === 1'b1 && lock_at < 0) lock_at = s;
    end
    n_vec++;
    if (lock_at != 24) begin
      n_miss++;
      $display("FAIL relock_latency: got step %0d want 24", lock_at);
    end
  endtask

  task automatic test_zero_input();
    logic saw_lock = 1'b0;
    step(1'b0, 0, 0, 1'b0, 1'b1);
    for (int s = 0; s < 60; s++) begin
      step(1'b1, 0, 0, 1'b0, 1'b0);
      if (locked !== 1'b0) saw_lock = 1'b1;
      n_vec++;
      if (rx_bits_vld !== 1'b1 || rx_bits !== 4'b1111) begin
        n_miss++;
        $display("FAIL zero_slice: got %b v %b want 1111 1", rx_bits, rx_bits_vld);
      end
    end
    idle();
    n_vec++;
    if (saw_lock || locked !== 1'b0) begin
      n_miss++;
      $display("FAIL zero_nolock: got locked seen %b want 0", saw_lock);
    end
  endtask

  task automatic test_slicer_edges();
    int         vals [5] = '{-1024, -1, 0, 1023, 1024};
    logic [1:0] want [5] = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b10};
    for (int k = 0; k < 5; k++) begin
      step(1'b1, vals[k], vals[k], 1'b0, 1'b0);
      n_vec++;
      if (rx_bits !== {want[k], want[k]}) begin
        n_miss++;
        $display("FAIL slicer_edge: x=%0d got %b want %b", vals[k], rx_bits, {want[k], want[k]});
      end
    end
  endtask

  task automatic test_clear();
    step(1'b0, 0, 0, 1'b0, 1'b1);
    for (int s = 0; s < 30; s++) send_sym(0, 1'b0);
    send_sym(0, 1'b0);
    send_sym(0, 1'b1);
    n_vec++;
    if (bit_count !== 48'd0 || err_count !== 32'd0 || locked !== 1'b1) begin
      n_miss++;
      $display("FAIL clear: got bits %0d errs %0d lk %b want 0 0 1", bit_count, err_count, locked);
    end
    idle();
    n_vec++;
    if (bit_count !== 48'd4) begin
      n_miss++;
      $display("FAIL clear_resume: got bits %0d want 4", bit_count);
    end
  endtask

  task automatic test_reset_mid();
    for (int s = 0; s < 10; s++) send_sym(0, 1'b0);
    step(1'b1, 512, -512, 1'b0, 1'b1);
    n_vec++;
    if ({rx_bits, rx_bits_vld, locked, lock_lost, win_done} !== 8'b0 ||
        bit_count !== 48'd0 || err_count !== 32'd0) begin
      n_miss++;
      $display("FAIL reset_mid: got rx %b v %b lk %b ll %b wd %b bits %0d errs %0d want all 0",
               rx_bits, rx_bits_vld, locked, lock_lost, win_done, bit_count, err_count);
    end
    for (int s = 0; s < 5; s++) send_sym(0, 1'b0);
  endtask

  initial begin
    model_reset();
    g = 23'h1;
    test_reset();
    test_lock();
    test_single_err();
    test_window_loss();
    test_zero_input();
    test_slicer_edges();
    test_clear();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
